// File: rtl/wave_fetch_arbiter.sv
// Round-robin fetch arbiter: picks the next wavefront whose instruction queue
// may be fetched, keeps at most one fetch in flight per wave, and drops
// requests or outstanding fetches for flushed waves.
//
// state  | meaning
// IDLE   | no request presented; searching for an eligible wave
// REQ    | fetch_valid high, fetch_wfid held until handshake or withdrawal
module wave_fetch_arbiter #(
    parameter int NUM_WF = 40,
    parameter int WFID_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_WF-1:0] wf_active,
    input  logic [NUM_WF-1:0] wf_stop_fetch,
    input  logic [NUM_WF-1:0] wf_flush,
    output logic              fetch_valid,
    output logic [WFID_W-1:0] fetch_wfid,
    input  logic              fetch_ready,
    input  logic              ack_valid,
    input  logic [WFID_W-1:0] ack_wfid,
    output logic [NUM_WF-1:0] wf_outstanding
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WFID_W-1:0] rr_ptr;
    logic [WFID_W-1:0] wfid_q;
    logic [NUM_WF-1:0] outst_q;
    logic [NUM_WF-1:0] elig;
    logic [NUM_WF-1:0] grant_mask;
    logic [NUM_WF-1:0] ack_mask;
    logic [WFID_W-1:0] sel;
    logic              any_elig;
    logic              handshake;
    logic              withdraw;

    // Wave id base+off, wrapped modulo NUM_WF (off never exceeds NUM_WF).
    function automatic logic [WFID_W-1:0] wrap_add(logic [WFID_W-1:0] base, int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_WF) s = s - NUM_WF;
        return WFID_W'(s);
    endfunction

    assign elig = wf_active & ~wf_stop_fetch & ~outst_q & ~wf_flush;

    // Shifting past the top bit yields zero, so out-of-range ack ids are ignored.
    assign grant_mask = NUM_WF'(1) << wfid_q;
    assign ack_mask   = ack_valid ? (NUM_WF'(1) << ack_wfid) : '0;

    assign handshake = (state == S_REQ) && fetch_ready;
    assign withdraw  = (state == S_REQ) && !fetch_ready &&
                       (|(grant_mask & (wf_flush | ~wf_active | wf_stop_fetch)));

    // Round-robin search from rr_ptr+1; scanning farthest-first lets the nearest win.
    always_comb begin
        sel      = '0;
        any_elig = 1'b0;
        for (int k = NUM_WF; k >= 1; k--) begin
            if (elig[wrap_add(rr_ptr, k)]) begin
                sel      = wrap_add(rr_ptr, k);
                any_elig = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_elig) state_nxt = S_REQ;
            S_REQ:   if (handshake || withdraw) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        fetch_valid    = (state == S_REQ);
        fetch_wfid     = wfid_q;
        wf_outstanding = outst_q;
    end

    // Request id, round-robin pointer and in-flight bits; flush beats a same-cycle grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= WFID_W'(NUM_WF - 1);
            wfid_q  <= '0;
            outst_q <= '0;
        end else begin
            if (state == S_IDLE && any_elig) wfid_q <= sel;
            if (handshake) rr_ptr <= wfid_q;
            outst_q <= ((outst_q & ~ack_mask) | (handshake ? grant_mask : '0)) & ~wf_flush;
        end
    end

endmodule

// File: tb/tb_wave_fetch_arbiter.sv
// Directed bench for wave_fetch_arbiter with hand-computed expectations.
module tb_wave_fetch_arbiter;

    localparam int NUM_WF = 40;
    localparam int WFID_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_WF-1:0] wf_active;
    logic [NUM_WF-1:0] wf_stop_fetch;
    logic [NUM_WF-1:0] wf_flush;
    logic              fetch_valid;
    logic [WFID_W-1:0] fetch_wfid;
    logic              fetch_ready;
    logic              ack_valid;
    logic [WFID_W-1:0] ack_wfid;
    logic [NUM_WF-1:0] wf_outstanding;

    int total = 0;
    int bad   = 0;

    wave_fetch_arbiter #(.NUM_WF(NUM_WF), .WFID_W(WFID_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .wf_active      (wf_active),
        .wf_stop_fetch  (wf_stop_fetch),
        .wf_flush       (wf_flush),
        .fetch_valid    (fetch_valid),
        .fetch_wfid     (fetch_wfid),
        .fetch_ready    (fetch_ready),
        .ack_valid      (ack_valid),
        .ack_wfid       (ack_wfid),
        .wf_outstanding (wf_outstanding)
    );

    always #5 clk = ~clk;

    function automatic logic [NUM_WF-1:0] bitn(int n);
        logic [NUM_WF-1:0] one;
        one = 1;
        return one << n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        wf_active     = '0;
        wf_stop_fetch = '0;
        wf_flush      = '0;
        fetch_ready   = 1'b0;
        ack_valid     = 1'b0;
        ack_wfid      = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", 64'(fetch_valid), 64'd0);
        check("rst_wfid", 64'(fetch_wfid), 64'd0);
        check("rst_outst", 64'(wf_outstanding), 64'd0);

        // Waves 0 and 1 alternate, one in flight each
        wf_active = 40'h3; fetch_ready = 1'b1;
        tick();
        check("alt_v1", 64'(fetch_valid), 64'd1);
        check("alt_id0", 64'(fetch_wfid), 64'd0);
        tick();
        check("alt_bubble", 64'(fetch_valid), 64'd0);
        check("alt_outst0", 64'(wf_outstanding), 64'h1);
        tick();
        check("alt_id1", 64'(fetch_wfid), 64'd1);
        check("alt_v2", 64'(fetch_valid), 64'd1);
        tick();
        check("alt_outst01", 64'(wf_outstanding), 64'h3);
        ack_valid = 1'b1; ack_wfid = 6'd0;
        tick();
        check("alt_blocked", 64'(fetch_valid), 64'd0);
        check("alt_ack0", 64'(wf_outstanding), 64'h2);
        ack_wfid = 6'd1;
        tick();
        check("alt_id0b", 64'(fetch_wfid), 64'd0);
        check("alt_v3", 64'(fetch_valid), 64'd1);
        check("alt_ack1", 64'(wf_outstanding), 64'h0);
        ack_valid = 1'b0;
        tick();
        check("alt_outst0b", 64'(wf_outstanding), 64'h1);
        tick();
        check("alt_id1b", 64'(fetch_wfid), 64'd1);

        // Wrap-around: rr_ptr at 39, waves 5 and 39 eligible -> 5 then 39
        do_reset();
        wf_active = bitn(5) | bitn(39); fetch_ready = 1'b1;
        tick();
        check("wrap_first", 64'(fetch_wfid), 64'd5);
        tick();
        tick();
        check("wrap_second", 64'(fetch_wfid), 64'd39);
        tick();
        check("wrap_outst", 64'(wf_outstanding), 64'(bitn(5) | bitn(39)));
        wf_stop_fetch = '1; ack_valid = 1'b1; ack_wfid = 6'd39;
        tick();
        ack_wfid = 6'd5;
        tick();
        check("wrap_idle", 64'(fetch_valid), 64'd0);
        check("wrap_acked", 64'(wf_outstanding), 64'd0);
        ack_valid = 1'b0; wf_stop_fetch = '0;
        tick();
        check("wrap_pick5", 64'(fetch_wfid), 64'd5);
        check("wrap_pick5_v", 64'(fetch_valid), 64'd1);
        tick();
        tick();
        check("wrap_pick39", 64'(fetch_wfid), 64'd39);

        // Stall: fetch_ready low holds request stable
        do_reset();
        wf_active = bitn(2);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("stall_v", 64'(fetch_valid), 64'd1);
            check("stall_id", 64'(fetch_wfid), 64'd2);
            tick();
        end
        check("stall_noout", 64'(wf_outstanding), 64'd0);
        fetch_ready = 1'b1;
        tick();
        check("stall_outst", 64'(wf_outstanding), 64'(bitn(2)));
        check("stall_done", 64'(fetch_valid), 64'd0);

        // Withdrawal by flush, pointer stays at 39 (picks 3 before 10)
        do_reset();
        wf_active = bitn(3);
        tick();
        check("wd_req", 64'(fetch_wfid), 64'd3);
        wf_flush = bitn(3);
        tick();
        check("wd_drop", 64'(fetch_valid), 64'd0);
        wf_flush = '0; wf_active = bitn(3) | bitn(10);
        tick();
        check("wd_ptr", 64'(fetch_wfid), 64'd3);
        ack_valid = 1'b1; ack_wfid = 6'd3;
        tick();
        ack_valid = 1'b0;
        check("wd_ack_outst", 64'(wf_outstanding), 64'd0);
        check("wd_ack_hold", 64'(fetch_valid), 64'd1);

        // Withdrawal by stop_fetch rising
        wf_stop_fetch = bitn(3);
        tick();
        check("wd_stop", 64'(fetch_valid), 64'd0);
        wf_stop_fetch = '0;

        // Handshake with simultaneous flush: bit stays clear
        do_reset();
        wf_active = bitn(4); fetch_ready = 1'b1;
        tick();
        check("hf_req", 64'(fetch_wfid), 64'd4);
        wf_flush = bitn(4);
        tick();
        check("hf_outst", 64'(wf_outstanding), 64'd0);
        wf_flush = '0;
        tick();
        check("hf_again_v", 64'(fetch_valid), 64'd1);
        check("hf_again_id", 64'(fetch_wfid), 64'd4);
        tick();
        check("hf_set", 64'(wf_outstanding), 64'(bitn(4)));
        ack_valid = 1'b1; ack_wfid = 6'd44;
        tick();
        check("hf_oor_ack", 64'(wf_outstanding), 64'(bitn(4)));
        ack_valid = 1'b0; wf_flush = bitn(4);
        tick();
        check("hf_flush_clr", 64'(wf_outstanding), 64'd0);
        wf_flush = '0; wf_active = '0;

        // All stopped: idle 20 cycles, then wave 7 released
        do_reset();
        wf_active = '1; wf_stop_fetch = '1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("stop_idle", 64'(fetch_valid), 64'd0);
        end
        wf_stop_fetch = ~bitn(7);
        tick();
        check("stop_rel_v", 64'(fetch_valid), 64'd1);
        check("stop_rel_id", 64'(fetch_wfid), 64'd7);

        // Reset in the middle of a request
        rst = 1'b1;
        tick();
        check("mid_rst_v", 64'(fetch_valid), 64'd0);
        check("mid_rst_id", 64'(fetch_wfid), 64'd0);
        check("mid_rst_out", 64'(wf_outstanding), 64'd0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
